md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have port CLK, in, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, in, 1, the reset: asynchronous, active-low (0 = reset).
REQ-003 SHALL have port START, in, 1, a request to run OP; sampled only in IDLE.
REQ-004 SHALL have port OP, in, 3, the operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 treated as NOP.
REQ-005 SHALL have ports OPA and OPB, in, 32 each: OPA is the multiplicand, dividend or MTHI/MTLO source; OPB is the multiplier or divisor.
REQ-006 SHALL have ports HI_I and LO_I, in, 32 each, the current HI and LO values from the HI/LO register.
REQ-007 SHALL have port CANCEL, in, 1, a pipeline flush that aborts the operation in flight.
REQ-008 SHALL have port BUSY, out, 1, a stall request to the pipeline.
REQ-009 SHALL have port HILO_WEN, out, 1, a one-cycle write enable to the HI/LO register.
REQ-010 SHALL have ports HI_DATA_O and LO_DATA_O, out, 32 each, the write data, valid while HILO_WEN=1.

Function
REQ-011 SHALL implement the states IDLE, MUL, DIV and WB.
REQ-012 SHALL, in IDLE with START=1, CANCEL=0 and OP in {MULT, MULTU, DIV, DIVU, MTHI, MTLO}, latch OP, OPA, OPB, HI_I and LO_I on that edge (the accept edge).
REQ-013 SHALL treat START with OP=NOP/111, or START while not in IDLE, as ignored: no state change and no latch.
REQ-014 SHALL go IDLE->MUL on an accepted MULT/MULTU, and SHALL register the 64-bit product (signed for MULT, unsigned for MULTU) in MUL; MUL->WB after 1 cycle.
REQ-015 SHALL go IDLE->DIV on an accepted DIV/DIVU with OPB!=0, and SHALL run a restoring radix-2 divide on operand magnitudes for exactly 32 cycles, one quotient bit per cycle, driven by a 6-bit counter; DIV->WB after the 32nd cycle.
REQ-016 SHALL, for signed DIV, make the quotient negative iff the operand signs differ and give the remainder the sign of the dividend; the quotient of 0x80000000 / 0xFFFFFFFF SHALL wrap to 0x80000000 with remainder 0.
REQ-017 SHALL, for DIV/DIVU with OPB=0, go IDLE->WB directly with HI=OPA and LO=0xFFFFFFFF.
REQ-018 SHALL, on MTHI, go IDLE->WB with HI=OPA and LO=latched LO_I; on MTLO, go IDLE->WB with HI=latched HI_I and LO=OPA.
REQ-019 SHALL, in WB, assert HILO_WEN=1 for exactly one cycle with results HI=high product/remainder and LO=low product/quotient, then go WB->IDLE unconditionally.
REQ-020 SHALL give HILO_WEN latency after the accept edge of: MTHI/MTLO and divide-by-0 in the 1st cycle; MULT/MULTU in the 2nd cycle; DIV/DIVU in the 33rd cycle.
REQ-021 SHALL drive BUSY combinationally as 1 when in MUL or DIV, or when in IDLE with an accepted MULT/MULTU/DIV/DIVU; otherwise BUSY=0, including in WB and for MTHI/MTLO.
REQ-022 SHALL, on CANCEL=1 in MUL or DIV, go to IDLE on the next edge with no HILO_WEN.
REQ-023 SHALL, on CANCEL=1 in WB, force HILO_WEN=0 combinationally and still go WB->IDLE.
REQ-024 SHALL, on CANCEL=1 together with START in IDLE, not accept the request (CANCEL wins).
REQ-025 SHALL hold HI_DATA_O and LO_DATA_O at their last value when HILO_WEN=0.

Reset
REQ-026 SHALL, while RST=0, immediately force state to IDLE, the counter to 0, HILO_WEN=0, BUSY=0, and HI_DATA_O=LO_DATA_O=0x00000000, independent of CLK.
REQ-027 SHALL, on reset asserted mid-MUL, mid-DIV or in WB, abort the operation with no HILO_WEN; the first START after RST returns to 1 SHALL be accepted normally.

Verification
REQ-028 Bench SHALL cover: MULT with OPA=0xFFFFFFFE, OPB=0x00000003 -> HILO_WEN in the 2nd cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 Bench SHALL cover: DIV with OPA=0xFFFFFFF9 (-7), OPB=2 -> BUSY held for 32 cycles, HILO_WEN in the 33rd cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFD; DIVU with 100/7 -> HI=2, LO=14.
REQ-030 Bench SHALL cover: DIVU with OPB=0, OPA=0x12345678 -> HILO_WEN in the 1st cycle, HI=0x12345678, LO=0xFFFFFFFF, BUSY=0 throughout.
REQ-031 Bench SHALL cover: MTLO with OPA=0xA5A5A5A5, HI_I=0x11111111 -> HILO_WEN in the 1st cycle, HI=0x11111111, LO=0xA5A5A5A5.
REQ-032 Bench SHALL cover: CANCEL in DIV cycle 10 -> IDLE next edge, no HILO_WEN; START during DIV -> ignored; START+CANCEL in IDLE -> not accepted.
REQ-033 Bench SHALL cover: RST=0 asynchronously in DIV cycle 20 -> outputs 0 immediately, no HILO_WEN; a MULT after release completes normally.

Source files
------------

// File: rtl/md_ctrl.sv
// Multiply/divide controller for a MIPS-style HI/LO unit: single-cycle multiply,
// 32-cycle restoring divide, MTHI/MTLO pass-through, one-cycle HI/LO write-back.
module md_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] OPA,
  input  logic [31:0] OPB,
  input  logic [31:0] HI_I,
  input  logic [31:0] LO_I,
  input  logic        CANCEL,
  output logic        BUSY,
  output logic        HILO_WEN,
  output logic [31:0] HI_DATA_O,
  output logic [31:0] LO_DATA_O
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic [W-1:0]    r_a, r_b;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_rem, r_quo, r_dvs;
  logic [W-1:0]    r_res_hi, r_res_lo;
  logic [W-1:0]    r_last_hi, r_last_lo;

  logic            w_is_mul, w_is_div, w_is_mt, w_b_zero, w_accept;
  logic            w_sdiv_in;
  logic [W-1:0]    w_a_mag, w_b_mag;
  logic            w_msx;
  logic [2*W-1:0]  w_pa, w_pb, w_prod;
  logic [W:0]      w_shift, w_diff;
  logic            w_ge;
  logic [W-1:0]    w_rem_nxt, w_quo_nxt;
  logic            w_q_neg, w_r_neg;
  logic [W-1:0]    w_rem_fix, w_quo_fix;

  // request decode
  assign w_is_mul  = (OP == OP_MULT) || (OP == OP_MULTU);
  assign w_is_div  = (OP == OP_DIV)  || (OP == OP_DIVU);
  assign w_is_mt   = (OP == OP_MTHI) || (OP == OP_MTLO);
  assign w_b_zero  = (OPB == '0);
  assign w_sdiv_in = (OP == OP_DIV);
  assign w_a_mag   = (w_sdiv_in && OPA[W-1]) ? (~OPA + W'(1)) : OPA;
  assign w_b_mag   = (w_sdiv_in && OPB[W-1]) ? (~OPB + W'(1)) : OPB;

  // one shared 64-bit multiplier; sign-extension selects MULT vs MULTU
  assign w_msx  = (r_op == OP_MULT);
  assign w_pa   = {{W{w_msx & r_a[W-1]}}, r_a};
  assign w_pb   = {{W{w_msx & r_b[W-1]}}, r_b};
  assign w_prod = w_pa * w_pb;

  // restoring divide step on magnitudes
  assign w_shift   = {r_rem, r_quo[W-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[W];
  assign w_rem_nxt = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
  assign w_quo_nxt = {r_quo[W-2:0], w_ge};
  assign w_q_neg   = (r_op == OP_DIV) && (r_a[W-1] ^ r_b[W-1]);
  assign w_r_neg   = (r_op == OP_DIV) && r_a[W-1];
  assign w_quo_fix = w_q_neg ? (~w_quo_nxt + W'(1)) : w_quo_nxt;
  assign w_rem_fix = w_r_neg ? (~w_rem_nxt + W'(1)) : w_rem_nxt;

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    BUSY        = 1'b0;
    HILO_WEN    = 1'b0;
    if (RST) begin
      case (r_state)
        S_IDLE: begin
          if (START && !CANCEL && (w_is_mul || w_is_div || w_is_mt)) begin
            w_accept = 1'b1;
            if (w_is_mul) begin
              w_state_nxt = S_MUL;
              BUSY        = 1'b1;
            end else if (w_is_div && !w_b_zero) begin
              w_state_nxt = S_DIV;
              BUSY        = 1'b1;
            end else begin
              w_state_nxt = S_WB;
            end
          end
        end
        S_MUL: begin
          BUSY        = 1'b1;
          w_state_nxt = CANCEL ? S_IDLE : S_WB;
        end
        S_DIV: begin
          BUSY = 1'b1;
          if (CANCEL)                    w_state_nxt = S_IDLE;
          else if (r_cnt == CW'(W - 1))  w_state_nxt = S_WB;
        end
        S_WB: begin
          HILO_WEN    = ~CANCEL;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // operand latch, divide iteration and result registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_res_hi  <= '0;
      r_res_lo  <= '0;
      r_last_hi <= '0;
      r_last_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= OP;
            r_a   <= OPA;
            r_b   <= OPB;
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= w_a_mag;
            r_dvs <= w_b_mag;
            if (OP == OP_MTHI) begin
              r_res_hi <= OPA;
              r_res_lo <= LO_I;
            end else if (OP == OP_MTLO) begin
              r_res_hi <= HI_I;
              r_res_lo <= OPA;
            end else if (w_is_div && w_b_zero) begin
              r_res_hi <= OPA;
              r_res_lo <= '1;
            end
          end
        end
        S_MUL: {r_res_hi, r_res_lo} <= w_prod;
        S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == CW'(W - 1)) begin
            r_res_hi <= w_rem_fix;
            r_res_lo <= w_quo_fix;
          end
        end
        S_WB: begin
          if (HILO_WEN) begin
            r_last_hi <= r_res_hi;
            r_last_lo <= r_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs show the fresh result during write-back, else the last written value
  assign HI_DATA_O = HILO_WEN ? r_res_hi : r_last_hi;
  assign LO_DATA_O = HILO_WEN ? r_res_lo : r_last_lo;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: vector table of complete operations plus
// hand-written cancel, ignored-start and asynchronous-reset sequences.
module tb_md_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OP = 3'b000;
  logic [31:0] OPA = '0, OPB = '0, HI_I = '0, LO_I = '0;
  logic        CANCEL = 1'b0;
  logic        BUSY, HILO_WEN;
  logic [31:0] HI_DATA_O, LO_DATA_O;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  md_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .HI_I(HI_I), .LO_I(LO_I), .CANCEL(CANCEL), .BUSY(BUSY),
    .HILO_WEN(HILO_WEN), .HI_DATA_O(HI_DATA_O), .LO_DATA_O(LO_DATA_O)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi_i, lo_i;
    logic        busy0;
    int          lat;
    int          busy_n;
    logic [31:0] e_hi, e_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // called at the sample point of cycle 1 after an accept edge
  task automatic watch(input int maxc, output int lat, output int busy_n,
                       output logic [31:0] h, output logic [31:0] l);
    lat = 0; busy_n = 0; h = '0; l = '0;
    for (int k = 1; k <= maxc; k++) begin
      if (HILO_WEN === 1'b1) begin
        lat = k; h = HI_DATA_O; l = LO_DATA_O;
        chk("busy_in_wb", 32'(BUSY), 32'd0);
        break;
      end
      busy_n += int'(BUSY);
      @(posedge CLK); #1;
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic cancel);
    @(negedge CLK);
    START = 1'b1; OP = op; OPA = a; OPB = b; HI_I = hi; LO_I = lo; CANCEL = cancel;
  endtask

  task automatic release_inputs();
    START = 1'b0; CANCEL = 1'b0;
    OPA = 32'hDEAD_BEEF; OPB = 32'h0BAD_F00D; HI_I = 32'h5555_5555; LO_I = 32'h6666_6666;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, busy_n;
    logic [31:0] h, l;
    drive(v.op, v.a, v.b, v.hi_i, v.lo_i, 1'b0);
    #1 chk({v.name, "_busy0"}, 32'(BUSY), 32'(v.busy0));
    @(posedge CLK); #1;
    release_inputs();
    watch(40, lat, busy_n, h, l);
    chk({v.name, "_lat"}, 32'(lat), 32'(v.lat));
    chk({v.name, "_hi"}, h, v.e_hi);
    chk({v.name, "_lo"}, l, v.e_lo);
    chk({v.name, "_busy_n"}, 32'(busy_n), 32'(v.busy_n));
    @(posedge CLK); #1;
    chk({v.name, "_wen_after"}, 32'(HILO_WEN), 32'd0);
    chk({v.name, "_hi_held"}, HI_DATA_O, v.e_hi);
    chk({v.name, "_lo_held"}, LO_DATA_O, v.e_lo);
    last_hi = v.e_hi; last_lo = v.e_lo;
  endtask

  // request that must be ignored: no busy, no write-back, outputs held
  task automatic expect_ignored(input string name, input logic [2:0] op, input logic cancel);
    int lat, busy_n;
    logic [31:0] h, l;
    drive(op, 32'h1234_0000, 32'h0000_0003, 32'h0, 32'h0, cancel);
    #1 chk({name, "_busy0"}, 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    release_inputs();
    watch(6, lat, busy_n, h, l);
    chk({name, "_no_wen"}, 32'(lat), 32'd0);
    chk({name, "_no_busy"}, 32'(busy_n), 32'd0);
    chk({name, "_hi_held"}, HI_DATA_O, last_hi);
  endtask

  initial begin
    int lat, busy_n;
    logic [31:0] h, l;

    //          name      op     a             b             hi_i          lo_i          b0  lat bn  e_hi          e_lo
    vecs[0]  = '{"mult",   3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0,        1, 2,  1,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu",  3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0,        1, 2,  1,  32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{"div_n7", 3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        1, 33, 32, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu",   3'd4, 32'd100,      32'd7,        32'h0,        32'h0,        1, 33, 32, 32'd2,        32'd14};
    vecs[4]  = '{"divu0",  3'd4, 32'h12345678, 32'h0,        32'h0,        32'h0,        0, 1,  0,  32'h12345678, 32'hFFFFFFFF};
    vecs[5]  = '{"mtlo",   3'd6, 32'hA5A5A5A5, 32'h0,        32'h11111111, 32'h22222222, 0, 1,  0,  32'h11111111, 32'hA5A5A5A5};
    vecs[6]  = '{"mthi",   3'd5, 32'hCAFEBABE, 32'h0,        32'h44444444, 32'h33333333, 0, 1,  0,  32'hCAFEBABE, 32'h33333333};
    vecs[7]  = '{"div_ovf",3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 33, 32, 32'h00000000, 32'h80000000};
    vecs[8]  = '{"div_pn", 3'd3, 32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        1, 33, 32, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{"mult_mn",3'd1, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        1, 2,  1,  32'h40000000, 32'h00000000};
    vecs[10] = '{"div_nn", 3'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0,        32'h0,        1, 33, 32, 32'hFFFFFFFE, 32'h0000000E};
    vecs[11] = '{"divu_mx",3'd4, 32'hFFFFFFFF, 32'd10,       32'h0,        32'h0,        1, 33, 32, 32'd5,        32'h19999999};
    vecs[12] = '{"div0_s", 3'd3, 32'h80000001, 32'h0,        32'h0,        32'h0,        0, 1,  0,  32'h80000001, 32'hFFFFFFFF};

    // reset state, with a request presented while in reset
    START = 1'b1; OP = 3'd1; OPA = 32'd5; OPB = 32'd6;
    #3;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_wen", 32'(HILO_WEN), 32'd0);
    chk("rst_hi", HI_DATA_O, 32'h0);
    chk("rst_lo", LO_DATA_O, 32'h0);
    START = 1'b0;
    @(negedge CLK); RST = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    expect_ignored("nop", 3'd0, 1'b0);
    expect_ignored("op7", 3'd7, 1'b0);
    expect_ignored("start_cancel", 3'd1, 1'b1);

    // cancel during divide cycle 10
    drive(3'd4, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0);
    @(posedge CLK); #1; release_inputs();
    repeat (9) begin @(posedge CLK); #1; end
    CANCEL = 1'b1;
    chk("cdiv_busy_c10", 32'(BUSY), 32'd1);
    @(posedge CLK); #1; CANCEL = 1'b0;
    chk("cdiv_idle_busy", 32'(BUSY), 32'd0);
    watch(40, lat, busy_n, h, l);
    chk("cdiv_no_wen", 32'(lat), 32'd0);
    chk("cdiv_hi_held", HI_DATA_O, last_hi);

    // cancel during multiply
    drive(3'd1, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0);
    @(posedge CLK); #1; release_inputs();
    CANCEL = 1'b1;
    @(posedge CLK); #1; CANCEL = 1'b0;
    watch(5, lat, busy_n, h, l);
    chk("cmul_no_wen", 32'(lat), 32'd0);
    chk("cmul_busy", 32'(busy_n), 32'd0);

    // cancel in write-back suppresses the write combinationally
    drive(3'd5, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge CLK); #1; release_inputs();
    CANCEL = 1'b1;
    #1;
    chk("cwb_wen", 32'(HILO_WEN), 32'd0);
    chk("cwb_hi_held", HI_DATA_O, last_hi);
    @(posedge CLK); #1; CANCEL = 1'b0;
    chk("cwb_wen_next", 32'(HILO_WEN), 32'd0);
    chk("cwb_busy_next", 32'(BUSY), 32'd0);

    // start during a divide is ignored; divide completes on time
    drive(3'd3, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 1'b0);
    @(posedge CLK); #1; release_inputs();
    repeat (4) begin @(posedge CLK); #1; end
    START = 1'b1; OP = 3'd5; OPA = 32'h77777777;
    chk("sdiv_busy_c5", 32'(BUSY), 32'd1);
    @(posedge CLK); #1; release_inputs();
    watch(40, lat, busy_n, h, l);
    chk("sdiv_lat", 32'(lat + 5), 32'd33);
    chk("sdiv_hi", h, 32'hFFFFFFFF);
    chk("sdiv_lo", l, 32'hFFFFFFFD);
    last_hi = 32'hFFFFFFFF; last_lo = 32'hFFFFFFFD;
    @(posedge CLK); #1;

    // asynchronous reset in divide cycle 20
    drive(3'd4, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0);
    @(posedge CLK); #1; release_inputs();
    repeat (19) begin @(posedge CLK); #1; end
    #2 RST = 1'b0;
    #1;
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_wen", 32'(HILO_WEN), 32'd0);
    chk("arst_hi", HI_DATA_O, 32'h0);
    chk("arst_lo", LO_DATA_O, 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    watch(20, lat, busy_n, h, l);
    chk("arst_no_wen", 32'(lat), 32'd0);
    chk("arst_hi_zero", HI_DATA_O, 32'h0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
